// File: rtl/iot_event_reporter.sv
// Purpose: turns per-device on/off level changes into a serial stream of change/on_off events.
// Latency: input change before edge k is pending at edge k; earliest change pulse after edge k+1.
// Backpressure: hold=1 stalls grants only; events accumulate, and a toggle that reverts while held cancels.
module iot_event_reporter #(
    parameter int N_DEV = 8,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] dev_status,
    input  logic             hold,
    output logic             change,
    output logic             on_off,
    output logic [ID_W-1:0]  dev_id,
    output logic             pending,
    output logic [7:0]       cancel_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PEND_ON  = 2'd1,
        PEND_OFF = 2'd2
    } dev_state_t;

    logic [N_DEV-1:0] status_q;
    dev_state_t       state_q [N_DEV];
    dev_state_t       state_d [N_DEV];
    logic [ID_W-1:0]  rr_ptr;

    logic [N_DEV-1:0] rise;
    logic [N_DEV-1:0] fall;
    logic [N_DEV-1:0] busy;

    logic             grant_vld;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  scan_idx;
    logic             grant_on;

    logic [7:0]       cancel_d;
    logic             pending_d;
    int               cancel_sum;
    logic             granted_i;

    assign rise = dev_status & ~status_q;
    assign fall = ~dev_status & status_q;

    // Flag every device that currently holds an unreported event.
    always_comb begin
        busy = '0;
        for (int i = 0; i < N_DEV; i++) begin
            busy[i] = (state_q[i] != IDLE);
        end
    end

    // Round-robin pick: first busy device after the last one granted.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int off = 1; off <= N_DEV; off++) begin
            if (int'(rr_ptr) + off >= N_DEV) begin
                scan_idx = ID_W'(int'(rr_ptr) + off - N_DEV);
            end else begin
                scan_idx = ID_W'(int'(rr_ptr) + off);
            end
            if (!hold && !grant_vld && busy[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    assign grant_on = (state_q[grant_idx] == PEND_ON);

    // Per-device next state; a granted device keeps any opposite edge seen in the same cycle.
    always_comb begin
        cancel_sum = 0;
        pending_d  = 1'b0;
        granted_i  = 1'b0;
        for (int i = 0; i < N_DEV; i++) begin
            state_d[i] = state_q[i];
            granted_i  = grant_vld && (grant_idx == ID_W'(i));
            case (state_q[i])
                IDLE: begin
                    if (rise[i]) begin
                        state_d[i] = PEND_ON;
                    end else if (fall[i]) begin
                        state_d[i] = PEND_OFF;
                    end
                end
                PEND_ON: begin
                    if (granted_i) begin
                        state_d[i] = fall[i] ? PEND_OFF : IDLE;
                    end else if (fall[i]) begin
                        state_d[i] = IDLE;
                        cancel_sum = cancel_sum + 1;
                    end
                end
                PEND_OFF: begin
                    if (granted_i) begin
                        state_d[i] = rise[i] ? PEND_ON : IDLE;
                    end else if (rise[i]) begin
                        state_d[i] = IDLE;
                        cancel_sum = cancel_sum + 1;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                end
            endcase
            pending_d = pending_d | (state_d[i] != IDLE);
        end
        if (int'(cancel_cnt) + cancel_sum > 255) begin
            cancel_d = 8'hFF;
        end else begin
            cancel_d = 8'(int'(cancel_cnt) + cancel_sum);
        end
    end

    // State, sampled levels, pointer and registered event outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q   <= '0;
            rr_ptr     <= ID_W'(N_DEV - 1);
            change     <= 1'b0;
            on_off     <= 1'b0;
            dev_id     <= '0;
            pending    <= 1'b0;
            cancel_cnt <= '0;
            for (int i = 0; i < N_DEV; i++) begin
                state_q[i] <= IDLE;
            end
        end else begin
            status_q   <= dev_status;
            pending    <= pending_d;
            cancel_cnt <= cancel_d;
            for (int i = 0; i < N_DEV; i++) begin
                state_q[i] <= state_d[i];
            end
            if (grant_vld) begin
                change <= 1'b1;
                on_off <= grant_on;
                dev_id <= grant_idx;
                rr_ptr <= grant_idx;
            end else begin
                change <= 1'b0;
                on_off <= 1'b0;
                dev_id <= '0;
            end
        end
    end

endmodule
